// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// Frame levels, parity select codes and FSM encoding.
package uart_tx_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit for a latched data word.
// Even parity is the XOR-reduce, odd parity its inverse.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_typ_i,
  output logic             par_o
);

  // Pick XOR or XNOR reduction by parity type
  always_comb begin
    par_o = ^data_i;
    if (par_typ_i == PAR_ODD) begin
      par_o = ~^data_i;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, WIDTH data bits LSB first,
// optional parity, stop. One bit per CLK cycle.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             par_typ_q, par_typ_d;
  logic             par_bit;

  uart_tx_parity_calc #(
    .WIDTH (WIDTH)
  ) u_par (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .par_o     (par_bit)
  );

  // State, counter and latched frame config
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  // Next state; inputs are only latched when leaving IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    unique case (state_q)
      ST_IDLE: begin
        if (DATA_VALID) begin
          state_d   = ST_START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Line level and busy decoded from registered state only
  always_comb begin
    TX_OUT = IDLE_LEVEL;
    Busy   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        TX_OUT = IDLE_LEVEL;
        Busy   = 1'b0;
      end
      ST_START: begin
        TX_OUT = START_BIT;
        Busy   = 1'b1;
      end
      ST_DATA: begin
        TX_OUT = data_q[cnt_q];
        Busy   = 1'b1;
      end
      ST_PARITY: begin
        TX_OUT = par_bit;
        Busy   = 1'b1;
      end
      ST_STOP: begin
        TX_OUT = STOP_BIT;
        Busy   = 1'b1;
      end
      default: begin
        TX_OUT = IDLE_LEVEL;
        Busy   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx.
// Frames captured bit by bit on the falling edge.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int n_chk;
  int n_pass;

  uart_tx #(
    .WIDTH (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .TX_OUT     (tx_out),
    .Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: random inputs during frame,
  // 2: stray valid pulses during DATA and STOP
  task automatic run_frame(
    input string       tag,
    input logic [7:0]  d,
    input logic        pe,
    input logic        pt,
    input logic [10:0] exp_frame,
    input int          len,
    input int          mode
  );
    logic [10:0] got;
    int          nbusy;
    got   = '0;
    nbusy = 0;
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      got[len-1-i] = tx_out;
      if (busy) nbusy++;
      data_valid = 1'b0;
      if (mode == 1) begin
        p_data  = 8'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
      if (mode == 2 && (i == 3 || i == len - 1)) begin
        data_valid = 1'b1;
        par_typ    = ~par_typ;
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    if (busy) nbusy++;
    check({tag, "_bits"}, 32'(got), 32'(exp_frame));
    check({tag, "_busy"}, nbusy, len);
    check({tag, "_idle"}, {31'd0, tx_out}, 32'd1);
    if (mode == 2) begin
      nbusy = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (busy || !tx_out) nbusy++;
      end
      check({tag, "_nosecond"}, nbusy, 0);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'd0, tx_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx", {31'd0, tx_out}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    run_frame("even_a5", 8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11, 0);
    run_frame("odd_a5", 8'hA5, 1'b1, 1'b1, 11'b0_10100101_1_1, 11, 0);
    run_frame("odd_01", 8'h01, 1'b1, 1'b1, 11'b0_10000000_0_1, 11, 0);
    run_frame("nopar_0f", 8'h0F, 1'b0, 1'b0, 11'b0_11110000_1, 10, 0);
    run_frame("rand_in", 8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11, 1);
    run_frame("stray_v", 8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11, 2);

    // Abort in the 4th data cycle
    @(negedge clk);
    p_data     = 8'hFF;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx_out}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_after_tx", {31'd0, tx_out}, 32'd1);
    run_frame("after_rst", 8'h3C, 1'b0, 1'b0, 11'b0_00111100_1, 10, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
